// File: rtl/mem_region_decoder_pkg.sv
// ============================================================================
// mem_map_pkg : shared types, constants and the region-hit helper
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_map_pkg;

  localparam int WAIT_W     = 4;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;
  localparam int MAX_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Callers zero-extend their address to MAX_ADDR_W; only masked bits matter.
  function automatic logic region_hit(input logic [MAX_ADDR_W-1:0] addr,
                                      input logic [MAX_ADDR_W-1:0] base,
                                      input logic [MAX_ADDR_W-1:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_region_decoder_if.sv
// ============================================================================
// mem_region_decoder_if : CPU-side and device-side bus of the region decoder
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_region_decoder_if #(
  parameter int REGIONS = 8,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8
);
  logic [ADDR_W-1:0]         memAddr;
  logic                      memStrobe;
  logic                      memWrite;
  logic [DATA_W-1:0]         memDataWrite;
  logic [DATA_W-1:0]         memDataRead;
  logic                      memReady;
  logic [REGIONS-1:0]        devStrobe;
  logic                      devWrite;
  logic [ADDR_W-1:0]         devAddr;
  logic [DATA_W-1:0]         devDataWrite;
  logic [REGIONS*DATA_W-1:0] devDataRead;
  logic                      unmappedErr;
  logic                      roViolation;
  logic                      errClear;
  logic                      errValid;
  logic [ADDR_W-1:0]         errAddr;

  modport master (
    output memAddr, memStrobe, memWrite, memDataWrite, devDataRead, errClear,
    input  memDataRead, memReady, devStrobe, devWrite, devAddr, devDataWrite,
           unmappedErr, roViolation, errValid, errAddr
  );

  modport slave (
    input  memAddr, memStrobe, memWrite, memDataWrite, devDataRead, errClear,
    output memDataRead, memReady, devStrobe, devWrite, devAddr, devDataWrite,
           unmappedErr, roViolation, errValid, errAddr
  );
endinterface

`default_nettype wire

// File: rtl/mem_region_decoder_match.sv
// ============================================================================
// mem_region_match : combinational priority matcher (index 0 wins)
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_region_match
  import mem_map_pkg::*;
#(
  parameter int                          REGIONS     = 8,
  parameter int                          ADDR_W      = 16,
  parameter int                          IDX_W       = 3,
  parameter logic [REGIONS*ADDR_W-1:0]   REGION_BASE = '0,
  parameter logic [REGIONS*ADDR_W-1:0]   REGION_MASK = '0,
  parameter logic [REGIONS*WAIT_W-1:0]   REGION_WAIT = '0,
  parameter logic [REGIONS-1:0]          REGION_RO   = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic [WAIT_W-1:0] wait_o,
  output logic              ro_o
);

  always_comb begin
    hit_o  = 1'b0;
    idx_o  = '0;
    wait_o = '0;
    ro_o   = 1'b0;
    // Scan from the top so the lowest matching index is the last writer.
    for (int i = REGIONS - 1; i >= 0; i--) begin
      if (region_hit(MAX_ADDR_W'(addr_i),
                     MAX_ADDR_W'(REGION_BASE[i*ADDR_W +: ADDR_W]),
                     MAX_ADDR_W'(REGION_MASK[i*ADDR_W +: ADDR_W]))) begin
        hit_o  = 1'b1;
        idx_o  = IDX_W'(i);
        wait_o = REGION_WAIT[i*WAIT_W +: WAIT_W];
        ro_o   = REGION_RO[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_region_decoder.sv
// ============================================================================
// mem_region_decoder : memory-map decoder and bus sequencer (FSM, waits, read mux)
// Optional error capture: DECODE_ERR_CAPTURE_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module mem_region_decoder
  import mem_map_pkg::*;
#(
  parameter int                          REGIONS     = 8,
  parameter int                          ADDR_W      = ADDR_W_DEF,
  parameter int                          DATA_W      = DATA_W_DEF,
  parameter logic [REGIONS*ADDR_W-1:0]   REGION_BASE = '0,
  parameter logic [REGIONS*ADDR_W-1:0]   REGION_MASK = '0,
  parameter logic [REGIONS*WAIT_W-1:0]   REGION_WAIT = '0,
  parameter logic [REGIONS-1:0]          REGION_RO   = '0,
  parameter logic [DATA_W-1:0]           FILL_VALUE  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_region_decoder_if.slave  bus
);

  localparam int IDX_W = (REGIONS > 1) ? $clog2(REGIONS) : 1;

  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic [WAIT_W-1:0] hit_wait;
  logic              hit_ro;

  mem_region_match #(
    .REGIONS     (REGIONS),
    .ADDR_W      (ADDR_W),
    .IDX_W       (IDX_W),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK),
    .REGION_WAIT (REGION_WAIT),
    .REGION_RO   (REGION_RO)
  ) u_match (
    .addr_i (bus.memAddr),
    .hit_o  (hit),
    .idx_o  (hit_idx),
    .wait_o (hit_wait),
    .ro_o   (hit_ro)
  );

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic                hit_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [WAIT_W-1:0]   cnt_q;
  logic [REGIONS-1:0]  devStrobe_q;
  logic                devWrite_q;
  logic [ADDR_W-1:0]   devAddr_q;
  logic [DATA_W-1:0]   devDataWrite_q;
  logic [DATA_W-1:0]   memDataRead_q;
  logic                memReady_q;
  logic                unmappedErr_q;
  logic                roViolation_q;
  logic                go_done;
  logic                ro_block;
  logic [DATA_W-1:0]   rd_data;

  assign ro_block = bus.memWrite && hit_ro;
  assign go_done  = ((state_q == ACCESS) && (wait_q == '0)) ||
                    ((state_q == WAIT) && (cnt_q == WAIT_W'(1)));
  assign rd_data  = hit_q ? bus.devDataRead[int'(idx_q)*DATA_W +: DATA_W] : FILL_VALUE;

  // Error accesses pass through ACCESS with zero waits so that memReady
  // lands one cycle after the error pulse, matching a zero-wait hit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      hit_q          <= 1'b0;
      wait_q         <= '0;
      cnt_q          <= '0;
      devStrobe_q    <= '0;
      devWrite_q     <= 1'b0;
      devAddr_q      <= '0;
      devDataWrite_q <= '0;
      memDataRead_q  <= '0;
      memReady_q     <= 1'b0;
      unmappedErr_q  <= 1'b0;
      roViolation_q  <= 1'b0;
    end else begin
      devStrobe_q   <= '0;
      memReady_q    <= 1'b0;
      unmappedErr_q <= 1'b0;
      roViolation_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.memStrobe) begin
            devAddr_q      <= bus.memAddr;
            devDataWrite_q <= bus.memDataWrite;
            devWrite_q     <= bus.memWrite;
            idx_q          <= hit_idx;
            hit_q          <= hit;
            wait_q         <= (hit && !ro_block) ? hit_wait : '0;
            state_q        <= ACCESS;
            if (!hit)          unmappedErr_q <= 1'b1;
            else if (ro_block) roViolation_q <= 1'b1;
            else               devStrobe_q   <= REGIONS'(1) << hit_idx;
          end
        end
        ACCESS: begin
          cnt_q   <= wait_q;
          state_q <= go_done ? DONE : WAIT;
        end
        WAIT: begin
          if (go_done) state_q <= DONE;
          else         cnt_q   <= cnt_q - WAIT_W'(1);
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (go_done) begin
        memReady_q <= 1'b1;
        if (!devWrite_q) memDataRead_q <= rd_data;
      end
    end
  end

  assign bus.devStrobe    = devStrobe_q;
  assign bus.devWrite     = devWrite_q;
  assign bus.devAddr      = devAddr_q;
  assign bus.devDataWrite = devDataWrite_q;
  assign bus.memDataRead  = memDataRead_q;
  assign bus.memReady     = memReady_q;
  assign bus.unmappedErr  = unmappedErr_q;
  assign bus.roViolation  = roViolation_q;

`ifdef DECODE_ERR_CAPTURE_EN
  logic              errValid_q;
  logic [ADDR_W-1:0] errAddr_q;

  // A new error outranks a same-cycle clear; only the first address is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      errValid_q <= 1'b0;
      errAddr_q  <= '0;
    end else if (unmappedErr_q || roViolation_q) begin
      errValid_q <= 1'b1;
      if (!errValid_q) errAddr_q <= devAddr_q;
    end else if (bus.errClear) begin
      errValid_q <= 1'b0;
    end
  end

  assign bus.errValid = errValid_q;
  assign bus.errAddr  = errAddr_q;
`else
  logic unused_errClear;
  assign unused_errClear = bus.errClear;
  assign bus.errValid    = 1'b0;
  assign bus.errAddr     = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_region_decoder.sv
// ============================================================================
// tb_mem_region_decoder : directed self-checking bench for mem_region_decoder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_region_decoder;

`ifdef DECODE_ERR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_region_decoder_if #(.REGIONS(4), .ADDR_W(16), .DATA_W(8)) ifa();
  mem_region_decoder_if #(.REGIONS(4), .ADDR_W(16), .DATA_W(8)) ifb();

  // Map A: R0 0000/F800 W0 RO, R1 E000/E000 W0, R2 4000/E000 W3, R3 7F00/FFF0 W1
  mem_region_decoder #(
    .REGIONS(4), .ADDR_W(16), .DATA_W(8),
    .REGION_BASE(64'h7F00_4000_E000_0000),
    .REGION_MASK(64'hFFF0_E000_E000_F800),
    .REGION_WAIT(16'h1300),
    .REGION_RO(4'b0001),
    .FILL_VALUE(8'h00)
  ) u_dut_a (.clk(clk), .reset(reset), .bus(ifa));

  // Map B: overlapping R1 7F00/FFF0 and R3 7F00/FF00
  mem_region_decoder #(
    .REGIONS(4), .ADDR_W(16), .DATA_W(8),
    .REGION_BASE(64'h7F00_4000_7F00_0000),
    .REGION_MASK(64'hFF00_E000_FFF0_F800),
    .REGION_WAIT(16'h1300),
    .REGION_RO(4'b0001),
    .FILL_VALUE(8'h00)
  ) u_dut_b (.clk(clk), .reset(reset), .bus(ifb));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One access on map A; lat counts cycles after the accept edge (T+1 = 1).
  task automatic acc(input logic [15:0] a, input logic w, input logic [7:0] d,
                     input logic clr, output int lat, output int nstb,
                     output logic [3:0] stb1, output logic ue, output logic rv);
    ifa.memAddr      = a;
    ifa.memWrite     = w;
    ifa.memDataWrite = d;
    ifa.memStrobe    = 1'b1;
    step();
    ifa.memStrobe = 1'b0;
    ifa.errClear  = clr;
    lat  = 1;
    nstb = 0;
    stb1 = ifa.devStrobe;
    ue   = ifa.unmappedErr;
    rv   = ifa.roViolation;
    while (!ifa.memReady && lat < 40) begin
      if (ifa.devStrobe != 4'b0) nstb++;
      step();
      ifa.errClear = 1'b0;
      lat++;
    end
    if (ifa.devStrobe != 4'b0) nstb++;
    ifa.errClear = 1'b0;
  endtask

  int         lat;
  int         nstb;
  int         nrdy;
  logic [3:0] stb1;
  logic       ue;
  logic       rv;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    ifa.memAddr = '0; ifa.memStrobe = 1'b0; ifa.memWrite = 1'b0;
    ifa.memDataWrite = '0; ifa.errClear = 1'b0;
    ifa.devDataRead = 32'hC3_3C_5A_A5;
    ifb.memAddr = '0; ifb.memStrobe = 1'b0; ifb.memWrite = 1'b0;
    ifb.memDataWrite = '0; ifb.errClear = 1'b0;
    ifb.devDataRead = 32'hC3_3C_5A_A5;
    step(); step();

    chk("rst_memReady", 32'(ifa.memReady), 0);
    chk("rst_devStrobe", 32'(ifa.devStrobe), 0);
    chk("rst_memDataRead", 32'(ifa.memDataRead), 0);
    chk("rst_devAddr", 32'(ifa.devAddr), 0);
    chk("rst_errValid", 32'(ifa.errValid), 0);
    reset = 1'b1;
    step();

    // 1: read R0 (RO region, reads allowed)
    acc(16'h0123, 1'b0, 8'h00, 1'b0, lat, nstb, stb1, ue, rv);
    chk("t1_strobe", 32'(stb1), 'b0001);
    chk("t1_lat", 32'(lat), 2);
    chk("t1_data", 32'(ifa.memDataRead), 'hA5);
    chk("t1_devAddr", 32'(ifa.devAddr), 'h0123);

    // back-to-back: strobe held through the memReady cycle
    ifa.memAddr = 16'hE000; ifa.memWrite = 1'b0; ifa.memStrobe = 1'b1;
    step();
    chk("b2b_ignored", 32'(ifa.devStrobe), 0);
    step();
    ifa.memStrobe = 1'b0;
    chk("b2b_strobe", 32'(ifa.devStrobe), 'b0010);
    step();
    chk("b2b_ready", 32'(ifa.memReady), 1);
    chk("b2b_data", 32'(ifa.memDataRead), 'h5A);
    step();

    // 2: read R2, three wait states
    acc(16'h4010, 1'b0, 8'h00, 1'b0, lat, nstb, stb1, ue, rv);
    chk("t2_strobe", 32'(stb1), 'b0100);
    chk("t2_nstb", 32'(nstb), 1);
    chk("t2_lat", 32'(lat), 5);
    chk("t2_data", 32'(ifa.memDataRead), 'h3C);
    step();

    // 3: write to RO region
    acc(16'h0100, 1'b1, 8'h55, 1'b0, lat, nstb, stb1, ue, rv);
    chk("t3_nstb", 32'(nstb), 0);
    chk("t3_rov", 32'(rv), 1);
    chk("t3_uerr", 32'(ue), 0);
    chk("t3_lat", 32'(lat), 2);
    chk("t3_data_kept", 32'(ifa.memDataRead), 'h3C);
    chk("t3_devWrite", 32'(ifa.devWrite), 1);
    chk("t3_devDataWrite", 32'(ifa.devDataWrite), 'h55);
    chk("t3_errValid", 32'(ifa.errValid), CAP ? 1 : 0);
    chk("t3_errAddr", 32'(ifa.errAddr), CAP ? 'h0100 : 0);
    ifa.errClear = 1'b1;
    step();
    ifa.errClear = 1'b0;
    chk("clr_errValid", 32'(ifa.errValid), 0);

    // 4: unmapped reads, first-error retention, clear vs new error
    acc(16'h9000, 1'b0, 8'h00, 1'b0, lat, nstb, stb1, ue, rv);
    chk("t4_uerr", 32'(ue), 1);
    chk("t4_rov", 32'(rv), 0);
    chk("t4_nstb", 32'(nstb), 0);
    chk("t4_lat", 32'(lat), 2);
    chk("t4_fill", 32'(ifa.memDataRead), 'h00);
    chk("t4_errAddr", 32'(ifa.errAddr), CAP ? 'h9000 : 0);
    step();
    acc(16'hA000, 1'b0, 8'h00, 1'b0, lat, nstb, stb1, ue, rv);
    chk("t4b_uerr", 32'(ue), 1);
    chk("t4b_errAddr_kept", 32'(ifa.errAddr), CAP ? 'h9000 : 0);
    step();
    acc(16'hA000, 1'b0, 8'h00, 1'b1, lat, nstb, stb1, ue, rv);
    chk("t4c_set_wins", 32'(ifa.errValid), CAP ? 1 : 0);
    step();

    // R3 on map A: single wait state
    acc(16'h7F05, 1'b0, 8'h00, 1'b0, lat, nstb, stb1, ue, rv);
    chk("r3_strobe", 32'(stb1), 'b1000);
    chk("r3_lat", 32'(lat), 3);
    chk("r3_data", 32'(ifa.memDataRead), 'hC3);
    step();

    // 5: overlap on map B, lowest index wins
    ifb.memAddr = 16'h7F05; ifb.memWrite = 1'b0; ifb.memStrobe = 1'b1;
    step();
    ifb.memStrobe = 1'b0;
    chk("t5_strobe", 32'(ifb.devStrobe), 'b0010);
    step();
    chk("t5_ready", 32'(ifb.memReady), 1);
    chk("t5_data", 32'(ifb.memDataRead), 'h5A);
    step();

    // 6: reset during WAIT of an R2 read
    ifa.memAddr = 16'h4010; ifa.memWrite = 1'b0; ifa.memStrobe = 1'b1;
    step();
    ifa.memStrobe = 1'b0;
    step();
    reset = 1'b0;
    #1;
    chk("t6_memReady", 32'(ifa.memReady), 0);
    chk("t6_memDataRead", 32'(ifa.memDataRead), 0);
    chk("t6_devAddr", 32'(ifa.devAddr), 0);
    chk("t6_devStrobe", 32'(ifa.devStrobe), 0);
    nrdy = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ifa.memReady || ifa.devStrobe != 4'b0) nrdy++;
    end
    chk("t6_no_ready", 32'(nrdy), 0);
    reset = 1'b1;
    step();
    acc(16'hE000, 1'b0, 8'h00, 1'b0, lat, nstb, stb1, ue, rv);
    chk("t6_post_strobe", 32'(stb1), 'b0010);
    chk("t6_post_lat", 32'(lat), 2);
    chk("t6_post_data", 32'(ifa.memDataRead), 'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
